// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and related schedulers.
//   arb_state_t : arbiter lock state (IDLE / LOCKED)
//   rr_pick()   : round-robin winner search over up to NREQ_MAX requesters
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned IDX_W    = $clog2(NREQ_MAX);

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req scanning upward from ptr, wrapping at nreq.
    // ptr must be below nreq; bits of req at or above nreq are ignored.
    function automatic rr_pick_t rr_pick(input logic [NREQ_MAX-1:0] req,
                                         input logic [IDX_W-1:0]    ptr,
                                         input int unsigned         nreq);
        rr_pick_t r;
        r = '0;
        for (int unsigned k = 0; k < NREQ_MAX; k++) begin
            int unsigned i;
            i = 32'(ptr) + k;
            if (i >= nreq) i = i - nreq;
            if (k < nreq && !r.found && req[i[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = i[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-and-priority-encode: finds the first active request at or
// after ptr_i, wrapping modulo NREQ.
//   req_i   : request vector
//   ptr_i   : round-robin start index (must be < NREQ)
//   found_o : at least one request is active
//   idx_o   : winning index (valid when found_o)
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             found_o,
    output logic [PTR_W-1:0] idx_o
);

    rr_pick_t pick;
    logic     unused_idx_hi;

    assign pick          = rr_pick(NREQ_MAX'(req_i), IDX_W'(ptr_i), NREQ);
    assign found_o       = pick.found;
    assign idx_o         = pick.idx[PTR_W-1:0];
    // Upper index bits are always zero when NREQ < NREQ_MAX.
    assign unused_idx_hi = ^pick.idx;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NREQ requesters, with
// bounded burst locking and a saturating overflow-event counter.
//   wrClk, reset        : write clock, synchronous active-low reset
//   req/reqData/reqLast : per-requester request, data and last-beat flag
//   gnt, wrEn, wdata    : one-hot grant, FIFO write enable and data (combinational)
//   full, overflow      : FIFO status inputs
//   busy, owner         : burst lock held, and its owner
//   ovfCount            : saturating count of cycles with overflow high
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                    wrClk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   reqData,
    input  logic [NREQ-1:0]         reqLast,
    output logic [NREQ-1:0]         gnt,
    output logic                    wrEn,
    output logic [WIDTH-1:0]        wdata,
    input  logic                    full,
    input  logic                    overflow,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [CNT_W-1:0]        ovfCount
);

    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam int unsigned BC_W  = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] BEAT_END = BC_W'(MAX_BURST - 1);

    arb_state_t       state_q;
    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] owner_q;
    logic [BC_W-1:0]  beat_cnt_q;
    logic [CNT_W-1:0] ovf_cnt_q;

    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        return (i == PTR_W'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_priority_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Grant is combinational so the FIFO takes the beat on the same edge.
    always_comb begin
        gnt = '0;
        if (reset && !full) begin
            if (state_q == IDLE) begin
                if (pick_found) gnt[pick_idx] = 1'b1;
            end else if (req[owner_q]) begin
                gnt[owner_q] = 1'b1;
            end
        end
    end

    always_comb begin
        wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) wdata = reqData[i*WIDTH +: WIDTH];
        end
    end

    assign wrEn     = |gnt;
    assign busy     = (state_q == LOCKED);
    assign owner    = owner_q;
    assign ovfCount = ovf_cnt_q;

    always_ff @(posedge wrClk) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            if (overflow && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 1'b1;
            // wrEn already folds in full, so a stalled beat changes nothing.
            unique case (state_q)
                IDLE: begin
                    if (wrEn) begin
                        if (reqLast[pick_idx] || MAX_BURST == 1) begin
                            rr_ptr_q <= next_idx(pick_idx);
                        end else begin
                            state_q    <= LOCKED;
                            owner_q    <= pick_idx;
                            beat_cnt_q <= BC_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (wrEn) begin
                        if (reqLast[owner_q] || beat_cnt_q == BEAT_END) begin
                            state_q    <= IDLE;
                            rr_ptr_q   <= next_idx(owner_q);
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the dual-clock FIFO between NREQ requesters, all in the write-clock domain.
- Supports bounded bursts: a granted requester keeps the port until it marks its last beat or MAX_BURST beats have been accepted.
- Never issues a write while the FIFO reports full.
- Tracks FIFO overflow events in a saturating counter for debug and scoreboard cross-checks.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, data word width; must equal the FIFO width
- MAX_BURST, 4, maximum beats per grant (1..16)
- CNT_W, 8, width of the overflow event counter

Ports:
- wrClk  input  1  write-domain clock; all logic on its posedge
- reset  input  1  synchronous, active-low reset
- req  input  NREQ  per-requester write request; data valid while high
- reqData  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- reqLast  input  NREQ  marks the requester's current beat as the last of its burst
- gnt  output  NREQ  one-hot; the beat of requester i is accepted this cycle
- wrEn  output  1  FIFO write enable (combinational, equals |gnt)
- wdata  output  WIDTH  FIFO write data, the granted requester's reqData
- full  input  1  FIFO full flag
- overflow  input  1  FIFO overflow flag
- busy  output  1  high while a burst lock is held
- owner  output  $clog2(NREQ)  current lock owner; valid only while busy
- ovfCount  output  CNT_W  saturating count of cycles with overflow=1

Behaviour:
- Reset (reset=0 at posedge): state=IDLE, rrPtr=0, beatCnt=0, owner=0, ovfCount=0.
- While reset=0, gnt=0 and wrEn=0 combinationally, regardless of req.
- wdata=0 whenever gnt=0.
- Acceptance: a beat is accepted in cycle t iff gnt[i]=1 in t. The FIFO samples wrEn/wdata at the same edge, giving zero-cycle latency.
- Requesters must hold req/reqData/reqLast stable until their gnt is seen.
- full=1 forces gnt=0 and wrEn=0. State, rrPtr and beatCnt are held.
- IDLE:
  - If full=0 and req!=0, the winner is the first i with req[i]=1, scanning from rrPtr upward modulo NREQ; gnt[winner]=1.
  - If reqLast[winner]=1 or MAX_BURST=1: stay IDLE, rrPtr=(winner+1)%NREQ.
  - Otherwise: go to LOCKED, owner=winner, beatCnt=1.
  - If req=0, nothing changes.
- LOCKED:
  - gnt[owner]=req[owner]&&!full. All other requesters are ignored.
  - On an accepted beat with reqLast[owner]=1 or beatCnt==MAX_BURST-1: go to IDLE, rrPtr=(owner+1)%NREQ, beatCnt=0.
  - On any other accepted beat: beatCnt++.
  - If the owner drops req, the lock is held (stall). Release happens only via last beat, max burst, or reset.
- busy=1 exactly in LOCKED; owner is a registered output.
- ovfCount increments on every posedge with overflow=1 and saturates at 2^CNT_W-1. It never wraps.
- Reset mid-burst: the lock is abandoned and rrPtr returns to 0; outstanding requests are re-arbitrated from requester 0.
- Simultaneous full=1 with a last-beat request: no acceptance, so no release. Release occurs on the cycle the beat is actually accepted.
- Arbitration is fair: with all requesters active and no full, grants rotate 0,1,..,NREQ-1 in units of complete bursts.

Decomposition:
- Shared package fifo_arb_pkg:
  - typedef enum {IDLE, LOCKED} arb_state_t
  - localparam IDX_W = $clog2(NREQ)
  - function rr_pick(req, rrPtr) returning winner index plus a found bit
- One natural sub-module, rr_priority_pick: combinational rotate-and-priority-encode of req from rrPtr. It is reusable by the read-side scheduler.

Test Plan:
- Reset: reset=0 with req=4'b1111 -> gnt=0, wrEn=0. After reset=1 and full=0, the first grant goes to requester 0.
- Round-robin: req=4'b1111 held, reqLast=4'b1111, full=0 -> gnt sequence 0001,0010,0100,1000,0001; the FIFO receives 4 words per 4 cycles.
- Burst cap: MAX_BURST=4, requester 2 streams with reqLast=0, requester 0 also requests -> requester 2 gets 4 consecutive grants, busy=1 on beats 2-4, then requester 3 is skipped and requester 0 is granted.
- Full stall: full=1 during the 2nd beat of a burst from requester 1 -> gnt=0 and wrEn=0 while full; busy stays 1 with owner=1; on full=0 the burst resumes with beatCnt unchanged.
- Overflow counter: overflow=1 for 300 cycles with CNT_W=8 -> ovfCount reaches 255 and holds; reset=0 returns it to 0.
- Reset mid-burst: reset=0 during beat 2 of requester 3's burst -> busy=0 next cycle, and the next grant goes to the lowest active requester from index 0.
